// File: rtl/lockin_iq_accum.sv
// -----------------------------------------------------------------------------
// lockin_iq_accum
//
// Lock-in I/Q demodulator that sits after the quadrature square-wave reference
// generator. Each ADC sample is multiplied by +/-1 according to the 0deg (I)
// and 90deg (Q) references. The products are summed over an integer number
// of reference periods. One result per measurement is handed to the host
// stage over a valid/ready pair.
//
// A measurement starts on a rising edge of sq_0deg and ends on the Nth
// following rising edge. The sample taken in the closing-edge cycle belongs
// to the next period, so it is left out. Every measurement therefore covers
// exactly N whole periods, and DC content cancels.
//
// Ports
//   clk_50M    in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   adc_data   in   ADC_W   signed two's-complement sample
//   adc_valid  in   1       adc_data valid this cycle
//   sq_0deg    in   1       0deg reference (same clock domain)
//   sq_90deg   in   1       90deg reference (same clock domain)
//   start      in   1       one-cycle measurement request (honoured in IDLE)
//   n_periods  in   PER_W   periods to integrate, 0 is treated as 1
//   busy       out  1       measurement in progress or result pending
//   i_out      out  ACC_W   I result, signed
//   q_out      out  ACC_W   Q result, signed
//   n_samples  out  SCNT_W  samples accumulated, saturating
//   ovf        out  1       an accumulator clamped during the measurement
//   out_valid  out  1       result valid, held until accepted
//   out_ready  in   1       consumer accepts when out_valid & out_ready
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the previous result
// ARM   | accumulators cleared, waiting for the first sq_0deg rising edge
// ACCUM | integrating samples, counting reference periods
// DONE  | result presented on out_valid until the consumer accepts it
// -----------------------------------------------------------------------------
module lockin_iq_accum #(
    parameter int ADC_W  = 12,
    parameter int ACC_W  = 40,
    parameter int PER_W  = 8,
    parameter int SCNT_W = 24
) (
    input  logic                     clk_50M,
    input  logic                     rst_n,
    input  logic signed [ADC_W-1:0]  adc_data,
    input  logic                     adc_valid,
    input  logic                     sq_0deg,
    input  logic                     sq_90deg,
    input  logic                     start,
    input  logic        [PER_W-1:0]  n_periods,
    output logic                     busy,
    output logic signed [ACC_W-1:0]  i_out,
    output logic signed [ACC_W-1:0]  q_out,
    output logic        [SCNT_W-1:0] n_samples,
    output logic                     ovf,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state_q;
    state_t state_d;

    logic                     sq_0deg_d;
    logic                     edge_det;
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;
    logic        [SCNT_W-1:0] scnt;
    logic        [PER_W-1:0]  period_cnt;
    logic        [PER_W-1:0]  n_lat;
    logic                     ovf_acc;

    logic        [PER_W:0]    period_next;
    logic                     close_edge;

    logic signed [ADC_W:0]    s_ext;
    logic signed [ADC_W:0]    term_i;
    logic signed [ADC_W:0]    term_q;
    logic        [ACC_W:0]    sum_i;
    logic        [ACC_W:0]    sum_q;
    logic                     clamp_i;
    logic                     clamp_q;
    logic        [ACC_W-1:0]  sat_i;
    logic        [ACC_W-1:0]  sat_q;

    logic                     clear_meas;
    logic                     incl_smp;
    logic                     period_inc;
    logic                     load_out;
    logic                     accept;

    // ------------------------------------------------------------------
    // Reference edge detection and period bookkeeping
    // ------------------------------------------------------------------
    assign edge_det    = sq_0deg & ~sq_0deg_d;
    assign period_next = {1'b0, period_cnt} + (PER_W+1)'(1);
    assign close_edge  = edge_det && (period_next == {1'b0, n_lat});

    // ------------------------------------------------------------------
    // +/-1 multiply and saturating accumulate.
    // The sample is widened by one bit first, so negating the most
    // negative code gives an exact positive term. The sum is formed with
    // one bit of headroom. When its top two bits differ, the true result
    // lies outside the ACC_W range and is clamped toward the sign of the
    // wide sum.
    // ------------------------------------------------------------------
    always_comb begin
        s_ext  = {adc_data[ADC_W-1], adc_data};
        term_i = sq_0deg  ? s_ext : -s_ext;
        term_q = sq_90deg ? s_ext : -s_ext;

        sum_i = {acc_i[ACC_W-1], acc_i} + {{(ACC_W-ADC_W){term_i[ADC_W]}}, term_i};
        sum_q = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-ADC_W){term_q[ADC_W]}}, term_q};

        clamp_i = sum_i[ACC_W] ^ sum_i[ACC_W-1];
        clamp_q = sum_q[ACC_W] ^ sum_q[ACC_W-1];

        sat_i = sum_i[ACC_W-1:0];
        if (clamp_i) begin
            sat_i = sum_i[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        sat_q = sum_q[ACC_W-1:0];
        if (clamp_q) begin
            sat_q = sum_q[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clear_meas = 1'b0;
        incl_smp   = 1'b0;
        period_inc = 1'b0;
        load_out   = 1'b0;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARM;
                    clear_meas = 1'b1;
                end
            end
            ARM: begin
                // The opening-edge sample is the first sample of period 0.
                if (edge_det) begin
                    state_d  = ACCUM;
                    incl_smp = adc_valid;
                end
            end
            ACCUM: begin
                if (close_edge) begin
                    // This cycle's sample opens the next period, so it is dropped.
                    state_d  = DONE;
                    load_out = 1'b1;
                end else begin
                    incl_smp   = adc_valid;
                    period_inc = edge_det;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    accept  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Measurement datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sq_0deg_d  <= 1'b0;
            acc_i      <= '0;
            acc_q      <= '0;
            scnt       <= '0;
            period_cnt <= '0;
            n_lat      <= '0;
            ovf_acc    <= 1'b0;
        end else begin
            sq_0deg_d <= sq_0deg;
            if (clear_meas) begin
                acc_i      <= '0;
                acc_q      <= '0;
                scnt       <= '0;
                period_cnt <= '0;
                ovf_acc    <= 1'b0;
                n_lat      <= (n_periods == '0) ? PER_W'(1) : n_periods;
            end else begin
                if (incl_smp) begin
                    acc_i   <= sat_i;
                    acc_q   <= sat_q;
                    ovf_acc <= ovf_acc | clamp_i | clamp_q;
                    if (scnt != '1) begin
                        scnt <= scnt + SCNT_W'(1);
                    end
                end
                if (period_inc) begin
                    period_cnt <= period_cnt + PER_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers. They are loaded once, in the closing-edge cycle,
    // and keep their contents until the next measurement completes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            i_out     <= '0;
            q_out     <= '0;
            n_samples <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (load_out) begin
                i_out     <= acc_i;
                q_out     <= acc_q;
                n_samples <= scnt;
                ovf       <= ovf_acc;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lockin_iq_accum.sv
module tb_lockin_iq_accum;

    logic                clk_50M = 1'b0;
    logic                rst_n;
    logic signed [11:0]  adc_data;
    logic                adc_valid;
    logic                sq_0deg;
    logic                sq_90deg;
    logic                start;
    logic        [7:0]   n_periods;
    logic                out_ready;

    logic                busy;
    logic signed [39:0]  i_out;
    logic signed [39:0]  q_out;
    logic        [23:0]  n_samples;
    logic                ovf;
    logic                out_valid;

    logic                busy16;
    logic signed [15:0]  i_out16;
    logic signed [15:0]  q_out16;
    logic        [23:0]  n_samples16;
    logic                ovf16;
    logic                out_valid16;

    always #10 clk_50M = ~clk_50M;

    lockin_iq_accum #(.ADC_W(12), .ACC_W(40), .PER_W(8), .SCNT_W(24)) u_dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .sq_0deg   (sq_0deg),
        .sq_90deg  (sq_90deg),
        .start     (start),
        .n_periods (n_periods),
        .busy      (busy),
        .i_out     (i_out),
        .q_out     (q_out),
        .n_samples (n_samples),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Narrow-accumulator copy on the same stimulus, used for saturation.
    lockin_iq_accum #(.ADC_W(12), .ACC_W(16), .PER_W(8), .SCNT_W(24)) u_dut16 (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .sq_0deg   (sq_0deg),
        .sq_90deg  (sq_90deg),
        .start     (start),
        .n_periods (n_periods),
        .busy      (busy16),
        .i_out     (i_out16),
        .q_out     (q_out16),
        .n_samples (n_samples16),
        .ovf       (ovf16),
        .out_valid (out_valid16),
        .out_ready (out_ready)
    );

    typedef struct {
        longint i40;
        longint q40;
        longint i16;
        longint q16;
        int     n;
        bit     ovf40;
        bit     ovf16;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;

    // Reference / stimulus state: 16-clock period, 90deg lags 0deg by 4.
    int          ph = 15;
    int          mode = 0;        // 0 DC, 1 in-phase +/-amp, 2 in-phase 2047/-2048
    int          amp = 0;
    logic [15:0] vmask = 16'hFFFF;
    bit          drop_close = 1'b0;
    int          ph0_seen = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // Sample-by-sample model. Each measurement starts on the phase-0 edge
    // and covers whole periods only.
    function automatic exp_t model(input int m, input int a, input int np,
                                   input logic [15:0] msk);
        exp_t   e;
        int     neff;
        longint s;
        longint ti;
        longint tq;
        longint v;
        bit     s0;
        bit     s90;
        e.i40 = 0; e.q40 = 0; e.i16 = 0; e.q16 = 0; e.n = 0;
        e.ovf40 = 1'b0; e.ovf16 = 1'b0;
        neff = (np == 0) ? 1 : np;
        for (int p = 0; p < neff; p++) begin
            for (int k = 0; k < 16; k++) begin
                if (!msk[k]) continue;
                s0  = (k < 8);
                s90 = (k >= 4) && (k < 12);
                case (m)
                    0:       s = a;
                    1:       s = s0 ? a : -a;
                    default: s = s0 ? 2047 : -2048;
                endcase
                ti = s0  ? s : -s;
                tq = s90 ? s : -s;
                v = sat(e.i40 + ti, 40); if (v != e.i40 + ti) e.ovf40 = 1'b1; e.i40 = v;
                v = sat(e.q40 + tq, 40); if (v != e.q40 + tq) e.ovf40 = 1'b1; e.q40 = v;
                v = sat(e.i16 + ti, 16); if (v != e.i16 + ti) e.ovf16 = 1'b1; e.i16 = v;
                v = sat(e.q16 + tq, 16); if (v != e.q16 + tq) e.ovf16 = 1'b1; e.q16 = v;
                e.n++;
            end
        end
        return e;
    endfunction

    task automatic drive();
        int s;
        sq_0deg  = (ph < 8);
        sq_90deg = (ph >= 4) && (ph < 12);
        case (mode)
            0:       s = amp;
            1:       s = sq_0deg ? amp : -amp;
            default: s = sq_0deg ? 2047 : -2048;
        endcase
        adc_data  = 12'(s);
        adc_valid = vmask[ph] && !(drop_close && (ph == 0) && (ph0_seen >= 1));
        if (ph == 0) ph0_seen++;
    endtask

    task automatic step();
        @(negedge clk_50M);
        ph = (ph + 1) % 16;
        drive();
    endtask

    // Pulse start while ph==8 so the next phase-0 edge is the opening edge.
    task automatic start_meas(input int m, input int a, input int np,
                              input logic [15:0] msk, input bit drop, input bit push);
        mode = m; amp = a; vmask = msk; drop_close = drop;
        while (ph != 8) step();
        ph0_seen  = 0;
        start     = 1'b1;
        n_periods = 8'(np);
        if (push) sb.push_back(model(m, a, np, msk));
        step();
        start     = 1'b0;
        n_periods = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 10000) begin
            step();
            n++;
        end
        chk({tag, "_valid_seen"}, out_valid, 1);
    endtask

    task automatic check_result(input string tag, output exp_t e);
        chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_i"},       i_out,       e.i40);
            chk({tag, "_q"},       q_out,       e.q40);
            chk({tag, "_n"},       n_samples,   e.n);
            chk({tag, "_ovf"},     ovf,         e.ovf40);
            chk({tag, "_i16"},     i_out16,     e.i16);
            chk({tag, "_q16"},     q_out16,     e.q16);
            chk({tag, "_ovf16"},   ovf16,       e.ovf16);
            chk({tag, "_valid16"}, out_valid16, 1);
        end else begin
            e.i40 = 0; e.q40 = 0; e.i16 = 0; e.q16 = 0; e.n = 0;
            e.ovf40 = 1'b0; e.ovf16 = 1'b0;
        end
    endtask

    task automatic run_simple(input string tag, input int m, input int a, input int np,
                              input logic [15:0] msk, input bit drop);
        exp_t e;
        start_meas(m, a, np, msk, drop, 1'b1);
        wait_valid(tag);
        check_result(tag, e);
        step();
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_idle"},       busy,      0);
    endtask

    initial begin
        exp_t e;
        bit   saw;

        rst_n     = 1'b0;
        start     = 1'b0;
        n_periods = 8'd0;
        out_ready = 1'b1;
        drive();
        #5;
        chk("reset_i",     i_out,     0);
        chk("reset_q",     q_out,     0);
        chk("reset_n",     n_samples, 0);
        chk("reset_ovf",   ovf,       0);
        chk("reset_valid", out_valid, 0);
        chk("reset_busy",  busy,      0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();

        // DC rejection over two whole periods
        run_simple("dc", 0, 100, 2, 16'hFFFF, 1'b0);
        // In-phase signal, four periods
        run_simple("inphase", 1, 100, 4, 16'hFFFF, 1'b0);

        // Asynchronous reset in the middle of ACCUM with samples flowing
        start_meas(1, 100, 4, 16'hFFFF, 1'b0, 1'b0);
        repeat (30) step();
        chk("rst_mid_busy_before", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_i",     i_out,     0);
        chk("rst_mid_q",     q_out,     0);
        chk("rst_mid_n",     n_samples, 0);
        chk("rst_mid_i16",   i_out16,   0);
        chk("rst_mid_busy",  busy,      0);
        chk("rst_mid_valid", out_valid, 0);
        repeat (2) step();
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (100) begin
            step();
            if (out_valid || busy) saw = 1'b1;
        end
        chk("rst_mid_no_result", saw, 0);

        // n_periods = 0 behaves as 1
        run_simple("nper0", 1, 100, 0, 16'hFFFF, 1'b0);
        // adc_valid low on the closing-edge cycle gives the same result
        run_simple("close_novalid", 1, 100, 1, 16'hFFFF, 1'b1);
        // Most negative code: -(-2048) must be an exact +2048 term
        run_simple("minus_min", 2, 0, 1, 16'hFFFF, 1'b0);
        // Sparse adc_valid: phases 3 and 11 never valid
        run_simple("gaps", 1, 300, 3, 16'hF7F7, 1'b0);

        // Backpressure: result held, start ignored while in DONE
        out_ready = 1'b0;
        start_meas(1, 50, 2, 16'hFFFF, 1'b0, 1'b1);
        wait_valid("bp");
        check_result("bp", e);
        for (int k = 0; k < 10; k++) begin
            start = (k == 4);
            step();
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_i_hold",     i_out,     e.i40);
            chk("bp_n_hold",     n_samples, e.n);
            chk("bp_busy_hold",  busy,      1);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_busy_drop",  busy,      0);
        chk("bp_i_kept",     i_out,     e.i40);
        repeat (20) step();
        chk("bp_start_ignored", busy, 0);

        // Saturation on the 16-bit instance, 255 periods of full scale
        run_simple("sat", 1, 2047, 255, 16'hFFFF, 1'b0);

        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
